// File: rtl/riscv_pu_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests, buffers responses with PCs.
// Optional performance counters are enabled by defining RISCV_IF_PERF_EN.
module riscv_pu_fetch_unit #(
  parameter int unsigned      XLEN         = 64,
  parameter int unsigned      ILEN         = 32,
  parameter int unsigned      FETCH_DEPTH  = 4,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            enable,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_flush_pc,
  output logic            o_imem_req_valid,
  output logic [XLEN-1:0] o_imem_req_addr,
  input  logic            i_imem_req_ready,
  input  logic            i_imem_rsp_valid,
  input  logic [ILEN-1:0] i_imem_rsp_data,
  output logic            o_valid,
  output logic [ILEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  input  logic            i_ready,
  output logic            o_flush
`ifdef RISCV_IF_PERF_EN
  ,
  output logic [31:0]     o_perf_fetched,
  output logic [31:0]     o_perf_flushes,
  output logic [31:0]     o_perf_dropped
`endif
);

  localparam int unsigned AW = $clog2(FETCH_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FETCH_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic            flush_q, flush_d;

  logic [ILEN-1:0] instr_mem_q [FETCH_DEPTH];
  logic [XLEN-1:0] pc_mem_q    [FETCH_DEPTH];

  logic            en_c;
  logic [CW:0]     used_c;
  logic            credit_c;
  logic            req_fire_c;
  logic            rsp_take_c;
  logic            rsp_drop_c;
  logic            push_c;
  logic            pop_c;
  logic [XLEN-1:0] flush_tgt_c;

  // Handshake qualification; a flush suppresses requests and pops in its cycle
  always_comb begin
    en_c        = enable & ~i_stall;
    used_c      = {1'b0, outstanding_q} + {1'b0, count_q};
    credit_c    = (used_c < DEPTH_C);
    req_fire_c  = o_imem_req_valid & i_imem_req_ready;
    rsp_take_c  = enable & i_imem_rsp_valid;
    rsp_drop_c  = rsp_take_c & (i_flush | (drop_cnt_q != '0));
    push_c      = rsp_take_c & ~rsp_drop_c;
    pop_c       = o_valid & i_ready & ~i_flush;
    flush_tgt_c = i_flush_pc & ~XLEN'(3);
  end

  assign o_imem_req_valid = en_c & ~i_flush & credit_c;
  assign o_imem_req_addr  = pc_q;
  assign o_valid          = (count_q != '0) & ~i_stall & enable;
  assign o_instr          = instr_mem_q[head_q];
  assign o_pc             = pc_mem_q[head_q];
  assign o_flush          = flush_q;

  // Next-state: everything freezes while enable is low
  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    flush_d       = flush_q;
    if (enable) begin
      flush_d       = i_flush;
      outstanding_d = outstanding_q + CW'(req_fire_c) - CW'(rsp_take_c);
      if (i_flush) begin
        // Every request still in flight belongs to the old stream
        pc_d       = flush_tgt_c;
        rsp_pc_d   = flush_tgt_c;
        count_d    = '0;
        head_d     = '0;
        tail_d     = '0;
        drop_cnt_d = outstanding_q - CW'(rsp_take_c);
      end else begin
        if (req_fire_c) pc_d = pc_q + XLEN'(4);
        if (rsp_drop_c) drop_cnt_d = drop_cnt_q - CW'(1);
        if (push_c) begin
          rsp_pc_d = rsp_pc_q + XLEN'(4);
          tail_d   = tail_q + AW'(1);
        end
        if (pop_c) head_d = head_q + AW'(1);
        count_d = count_q + CW'(push_c) - CW'(pop_c);
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pc_q          <= RESET_VECTOR;
      rsp_pc_q      <= RESET_VECTOR;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      flush_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      flush_q       <= flush_d;
    end
  end

  // Queue storage needs no reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (push_c) begin
      instr_mem_q[tail_q] <= i_imem_rsp_data;
      pc_mem_q[tail_q]    <= rsp_pc_q;
    end
  end

`ifdef RISCV_IF_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(pop_c);
    perf_flushes_d = perf_flushes_q + 32'(enable & i_flush);
    perf_dropped_d = perf_dropped_q + 32'(rsp_drop_c);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      perf_fetched_q <= '0;
      perf_flushes_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushes_q <= perf_flushes_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end

  assign o_perf_fetched = perf_fetched_q;
  assign o_perf_flushes = perf_flushes_q;
  assign o_perf_dropped = perf_dropped_q;
`endif

  // Credit invariants: buffered plus in-flight never exceeds the queue, drops are a subset of in-flight
  a_credit: assert property (@(posedge clk) disable iff (!nreset) used_c <= DEPTH_C);
  a_drops:  assert property (@(posedge clk) disable iff (!nreset) drop_cnt_q <= outstanding_q);

endmodule

// File: tb/tb_riscv_pu_fetch_unit.sv
// Randomized bench for riscv_pu_fetch_unit against a queue-based model of requests, drops and delivery.
module tb_riscv_pu_fetch_unit;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            nreset;
  logic            enable, i_stall, i_flush;
  logic [XLEN-1:0] i_flush_pc;
  logic            o_imem_req_valid;
  logic [XLEN-1:0] o_imem_req_addr;
  logic            i_imem_req_ready;
  logic            i_imem_rsp_valid;
  logic [ILEN-1:0] i_imem_rsp_data;
  logic            o_valid;
  logic [ILEN-1:0] o_instr;
  logic [XLEN-1:0] o_pc;
  logic            i_ready;
  logic            o_flush;

  riscv_pu_fetch_unit #(.XLEN(XLEN), .ILEN(ILEN), .FETCH_DEPTH(DEPTH), .RESET_VECTOR('0)) dut (
    .clk(clk), .nreset(nreset), .enable(enable), .i_stall(i_stall),
    .i_flush(i_flush), .i_flush_pc(i_flush_pc),
    .o_imem_req_valid(o_imem_req_valid), .o_imem_req_addr(o_imem_req_addr),
    .i_imem_req_ready(i_imem_req_ready),
    .i_imem_rsp_valid(i_imem_rsp_valid), .i_imem_rsp_data(i_imem_rsp_data),
    .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc), .i_ready(i_ready),
    .o_flush(o_flush)
  );

  always #5 clk = ~clk;

  // In-flight request: its address, the word memory will return, and whether it is still wanted
  typedef struct { logic [63:0] addr; logic [31:0] data; bit live; } fl_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; } q_t;

  fl_t         inflight[$];
  q_t          expq[$];
  logic [63:0] m_pc;
  bit          m_flush;
  int          checks = 0;
  int          errors = 0;

  bit          s_en, s_stall, s_flush, s_rready, s_dready, s_rsp;
  logic [63:0] s_fpc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = '0;
    m_flush = 1'b0;
    inflight.delete();
    expq.delete();
  endtask

  // Drive one cycle of stimulus at the falling edge, then let it settle
  task automatic apply();
    enable           = s_en;
    i_stall          = s_stall;
    i_flush          = s_flush;
    i_flush_pc       = s_fpc;
    i_imem_req_ready = s_rready;
    i_ready          = s_dready;
    if (!nreset) model_reset();
    if (s_rsp && s_en && nreset && inflight.size() > 0) begin
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = inflight[0].data;
    end else begin
      i_imem_rsp_valid = 1'b0;
      i_imem_rsp_data  = $urandom;
    end
    #1;
  endtask

  // Compare against the model, advance the model across the rising edge
  task automatic finish_cycle();
    bit  exp_req, exp_v;
    fl_t e;
    exp_req = s_en && !s_stall && !s_flush && (inflight.size() + expq.size() < DEPTH);
    exp_v   = (expq.size() != 0) && !s_stall && s_en;
    chk("req_valid", 64'(o_imem_req_valid), 64'(exp_req));
    if (exp_req) chk("req_addr", o_imem_req_addr, m_pc);
    chk("o_valid", 64'(o_valid), 64'(exp_v));
    if (exp_v) begin
      chk("o_pc", o_pc, expq[0].pc);
      chk("o_instr", 64'(o_instr), 64'(expq[0].instr));
    end
    chk("o_flush", 64'(o_flush), 64'(m_flush));
    if (nreset && s_en) begin
      if (!s_flush && exp_v && s_dready) void'(expq.pop_front());
      if (i_imem_rsp_valid) begin
        e = inflight.pop_front();
        if (e.live && !s_flush) expq.push_back('{pc: e.addr, instr: e.data});
      end
      if (exp_req && s_rready) begin
        inflight.push_back('{addr: m_pc, data: $urandom, live: 1'b1});
        m_pc = m_pc + 64'd4;
      end
      if (s_flush) begin
        m_pc = s_fpc & ~64'd3;
        foreach (inflight[i]) inflight[i].live = 1'b0;
        expq.delete();
      end
      m_flush = s_flush;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc();
    apply();
    finish_cycle();
  endtask

  task automatic drain();
    s_dready = 1'b1; s_rready = 1'b0; s_rsp = 1'b1; s_stall = 1'b0; s_flush = 1'b0; s_en = 1'b1;
    for (int i = 0; i < 40 && (inflight.size() + expq.size()) != 0; i++) cyc();
    chk("drain_timeout", 64'(inflight.size() + expq.size()), 64'd0);
  endtask

  // Run until the first delivered instruction and pin its PC
  task automatic first_pc(input string name, input logic [63:0] want);
    logic [63:0] got;
    bit          seen;
    got  = 64'hDEAD_BEEF_DEAD_BEEF;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      apply();
      if (o_valid) begin
        got  = o_pc;
        seen = 1'b1;
      end
      finish_cycle();
    end
    chk(name, got, want);
  endtask

  initial begin
    nreset = 1'b0;
    s_en = 0; s_stall = 0; s_flush = 0; s_fpc = '0; s_rready = 1; s_dready = 1; s_rsp = 0;
    apply();
    chk("rst_req_valid", 64'(o_imem_req_valid), 64'd0);
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_flush", 64'(o_flush), 64'd0);
    finish_cycle();
    cyc();
    nreset = 1'b1;

    // Streaming with immediate responses
    s_en = 1; s_rsp = 1;
    apply();
    chk("first_req_valid", 64'(o_imem_req_valid), 64'd1);
    chk("first_addr", o_imem_req_addr, 64'h0);
    finish_cycle();
    apply();
    chk("second_addr", o_imem_req_addr, 64'h4);
    finish_cycle();
    repeat (10) cyc();

    // Decode backpressure fills the queue, one pop frees one request slot
    s_dready = 0;
    repeat (10) cyc();
    apply();
    chk("full_no_req", 64'(o_imem_req_valid), 64'd0);
    chk("full_valid", 64'(o_valid), 64'd1);
    finish_cycle();
    s_dready = 1;
    cyc();
    s_dready = 0;
    apply();
    chk("refill_req", 64'(o_imem_req_valid), 64'd1);
    finish_cycle();

    // Flush with three requests in flight
    drain();
    s_rready = 1; s_rsp = 0;
    repeat (3) cyc();
    s_flush = 1; s_fpc = 64'h1002;
    apply();
    chk("flush_no_req", 64'(o_imem_req_valid), 64'd0);
    finish_cycle();
    s_flush = 0; s_rsp = 1;
    apply();
    chk("post_flush_addr", o_imem_req_addr, 64'h1000);
    chk("o_flush_pulse", 64'(o_flush), 64'd1);
    finish_cycle();
    apply();
    chk("o_flush_drop", 64'(o_flush), 64'd0);
    finish_cycle();
    first_pc("first_pc_flush", 64'h1000);

    // Flush coinciding with a response, two outstanding
    drain();
    s_rready = 1; s_rsp = 0;
    repeat (2) cyc();
    s_rready = 0; s_flush = 1; s_fpc = 64'h2000; s_rsp = 1;
    cyc();
    s_flush = 0; s_rready = 1;
    first_pc("first_pc_coincident", 64'h2000);

    // Stall with responses pending
    drain();
    s_rready = 1; s_rsp = 0;
    repeat (3) cyc();
    s_stall = 1; s_rsp = 1;
    repeat (5) begin
      apply();
      chk("stall_req", 64'(o_imem_req_valid), 64'd0);
      chk("stall_valid", 64'(o_valid), 64'd0);
      finish_cycle();
    end
    s_stall = 0;
    repeat (10) cyc();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      s_en     = ($urandom % 100) < 90;
      s_stall  = ($urandom % 100) < 15;
      s_flush  = ($urandom % 100) < 5;
      s_fpc    = {$urandom, $urandom};
      s_rready = ($urandom % 100) < 70;
      s_dready = ($urandom % 100) < 70;
      s_rsp    = ($urandom % 100) < 60;
      cyc();
    end

    // Reset in the middle of a full queue
    s_en = 1; s_stall = 0; s_flush = 0; s_dready = 0; s_rready = 1; s_rsp = 1;
    repeat (10) cyc();
    nreset = 1'b0; s_en = 0;
    apply();
    chk("rst_mid_valid", 64'(o_valid), 64'd0);
    chk("rst_mid_addr", o_imem_req_addr, 64'h0);
    chk("rst_mid_flush", 64'(o_flush), 64'd0);
    finish_cycle();
    nreset = 1'b1; s_en = 1; s_dready = 1;
    apply();
    chk("rst_mid_first_addr", o_imem_req_addr, 64'h0);
    finish_cycle();
    repeat (10) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
